// File: rtl/wb_cmd_pkg.sv
// Shared types and defaults for the Wishbone command master: FSM state encoding,
// default widths, and the read-data value returned on writes and timeouts.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned AW_DEFAULT      = 32;
  localparam int unsigned DW_DEFAULT      = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Replicated across the data width for writes and timed-out transfers.
  localparam logic RDATA_ERR_FILL = 1'b0;

endpackage

// File: rtl/wb_cmd_master_timeout.sv
// Ack-wait counter for the Wishbone command master.
// It is held at zero by clr, counts up while en is high, and stops at TIMEOUT-1.
module wb_cmd_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response out.
// Define WB_CMD_MASTER_TIMEOUT_EN to abort a bus cycle that has not been acked after TIMEOUT cycles.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | cmd_ready high, waiting for cmd_valid
//   BUS   | cyc/stb asserted from the captured command, waiting for ack
//   RESP  | rsp_valid high, holding rdata/err until rsp_ready
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int unsigned AW      = AW_DEFAULT,
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic [DW-1:0]   i_wb_data
);

  if (TIMEOUT < 2) begin : g_timeout_range_check
    $error("wb_cmd_master: TIMEOUT must be at least 2");
  end

  state_e          state_q,     state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q,   rsp_err_d;
  logic            wb_cyc_q,    wb_cyc_d;
  logic            wb_we_q,     wb_we_d;
  logic [AW-1:0]   wb_addr_q,   wb_addr_d;
  logic [DW-1:0]   wb_data_q,   wb_data_d;
  logic [DW/8-1:0] wb_sel_q,    wb_sel_d;
  logic            tmo_expired;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  // Held clear outside BUS so the first BUS cycle always sees a count of zero.
  wb_cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q != BUS),
    .en      (state_q == BUS),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wb_cyc_d    = wb_cyc_q;
    wb_we_d     = wb_we_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_sel_d    = wb_sel_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        // cmd_ready_q is low for the first cycle out of reset, so no accept there.
        if (cmd_ready_q && cmd_valid) begin
          cmd_ready_d = 1'b0;
          wb_cyc_d    = 1'b1;
          wb_we_d     = cmd_we;
          wb_addr_d   = cmd_addr;
          wb_data_d   = cmd_wdata;
          wb_sel_d    = cmd_sel;
          state_d     = BUS;
        end
      end
      BUS: begin
        if (i_wb_ack) begin
          wb_cyc_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wb_we_q ? {DW{RDATA_ERR_FILL}} : i_wb_data;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (tmo_expired) begin
          wb_cyc_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = {DW{RDATA_ERR_FILL}};
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        wb_cyc_d    = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wb_cyc_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_sel_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_we_q     <= wb_we_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_sel_q    <= wb_sel_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign o_wb_cyc  = wb_cyc_q;
  assign o_wb_stb  = wb_cyc_q;
  assign o_wb_we   = wb_we_q;
  assign o_wb_addr = wb_addr_q;
  assign o_wb_data = wb_data_q;
  assign o_wb_sel  = wb_sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: transaction-level timeline model plus per-cycle compare.
// Honours WB_CMD_MASTER_TIMEOUT_EN when deciding whether a slow slave should time out.
module tb_wb_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_ack = 1'b0;
  logic [DW-1:0] i_wb_data = '0;

  wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .o_wb_cyc  (o_wb_cyc),
    .o_wb_stb  (o_wb_stb),
    .o_wb_we   (o_wb_we),
    .o_wb_addr (o_wb_addr),
    .o_wb_data (o_wb_data),
    .o_wb_sel  (o_wb_sel),
    .i_wb_ack  (i_wb_ack),
    .i_wb_data (i_wb_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, maintained by the stimulus process.
  bit            chk_en = 1'b0;
  logic          exp_cmd_ready, exp_cyc, exp_rsp_valid;
  bit            exp_fields = 1'b0;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [3:0]    exp_sel;
  bit            exp_rsp_fields = 1'b0;
  logic [DW-1:0] exp_rdata;
  logic          exp_err;
  int            cyc_hi = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, exp_cmd_ready);
      chk("wb_cyc", o_wb_cyc, exp_cyc);
      chk("wb_stb", o_wb_stb, exp_cyc);
      chk("rsp_valid", rsp_valid, exp_rsp_valid);
      if (exp_fields) begin
        chk("wb_we", o_wb_we, exp_we);
        chk("wb_addr", o_wb_addr, exp_addr);
        chk("wb_data", o_wb_data, exp_data);
        chk("wb_sel", o_wb_sel, exp_sel);
      end
      if (exp_rsp_fields) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, exp_err);
      end
      if (o_wb_cyc) cyc_hi++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset_values(input logic rdy);
    exp_cmd_ready  = rdy;
    exp_cyc        = 1'b0;
    exp_rsp_valid  = 1'b0;
    exp_fields     = 1'b1;
    exp_we         = 1'b0;
    exp_addr       = '0;
    exp_data       = '0;
    exp_sel        = '0;
    exp_rsp_fields = 1'b1;
    exp_rdata      = '0;
    exp_err        = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    i_wb_ack  = 1'b0;
    repeat (n) begin
      step();
      chk_en = 1'b1;
      expect_reset_values(1'b0);
    end
    reset_n = 1'b1;
    step();
    expect_reset_values(1'b1);
  endtask

  task automatic scramble_cmd();
    cmd_we    = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_sel   = 4'($urandom_range(0, 15));
  endtask

  logic [DW-1:0] last_rdata;
  logic          last_err;
  int            last_bus;

  // One full command: optional idle noise, accept, ws wait states, response held rsp_hold cycles.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [3:0] sel, input int ws, input logic [DW-1:0] sdata,
                         input int rsp_hold, input bit noise);
    int  nbus;
    bit  acked;
    if (noise) begin
      repeat ($urandom_range(0, 2)) begin
        i_wb_ack  = 1'($urandom_range(0, 1));
        i_wb_data = $urandom;
        step();
      end
      i_wb_ack = 1'b0;
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_sel   = sel;
    step();
    cyc_hi         = 0;
    exp_cmd_ready  = 1'b0;
    exp_cyc        = 1'b1;
    exp_rsp_valid  = 1'b0;
    exp_fields     = 1'b1;
    exp_we         = we;
    exp_addr       = addr;
    exp_data       = wdata;
    exp_sel        = sel;
    exp_rsp_fields = 1'b0;
    if (noise) scramble_cmd();
    else cmd_valid = 1'b0;

    acked = !(TMO_EN && (ws + 1 > TO));
    nbus  = acked ? ws + 1 : TO;
    for (int i = 1; i <= nbus; i++) begin
      i_wb_ack  = (i == ws + 1);
      i_wb_data = (i == ws + 1) ? sdata : $urandom;
      if (noise) scramble_cmd();
      step();
    end
    i_wb_ack = 1'b0;

    exp_cyc        = 1'b0;
    exp_fields     = 1'b0;
    exp_rsp_valid  = 1'b1;
    exp_rsp_fields = 1'b1;
    exp_err        = !acked;
    exp_rdata      = (!acked || we) ? '0 : sdata;
    last_rdata     = rsp_rdata;
    last_err       = rsp_err;
    last_bus       = cyc_hi;

    repeat (rsp_hold) begin
      rsp_ready = 1'b0;
      if (noise) begin
        i_wb_ack  = 1'($urandom_range(0, 1));
        i_wb_data = $urandom;
        scramble_cmd();
      end
      step();
    end
    rsp_ready = 1'b1;
    i_wb_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    rsp_ready      = 1'b0;
    cmd_valid      = 1'b0;
    i_wb_ack       = 1'b0;
    exp_cmd_ready  = 1'b1;
    exp_rsp_valid  = 1'b0;
    exp_rsp_fields = 1'b0;
  endtask

  initial begin
    do_reset(3);

    // Zero-wait write.
    run_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'hDEAD_BEEF, 0, 1'b0);
    chk("write_bus_cycles", last_bus, 1);
    chk("write_rdata", last_rdata, 32'h0);
    chk("write_err", last_err, 0);

    // Read with three wait states.
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 0, 1'b0);
    chk("read_bus_cycles", last_bus, 4);
    chk("read_rdata", last_rdata, 32'hCAFE_F00D);

    // Response backpressure with command and ack noise.
    run_txn(1'b0, 32'h3000_0020, 32'h1111_2222, 4'h3, 1, 32'h1234_5678, 5, 1'b1);
    chk("bp_rdata", last_rdata, 32'h1234_5678);

    // Slave too slow for the timeout: aborts when enabled, completes late otherwise.
    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 9, 32'h5555_AAAA, 1, 1'b0);
    chk("slow_bus_cycles", last_bus, TMO_EN ? 8 : 10);
    chk("slow_err", last_err, TMO_EN ? 1 : 0);
    chk("slow_rdata", last_rdata, TMO_EN ? 32'h0 : 32'h5555_AAAA);

    // Ack in the last allowed cycle wins over expiry.
    run_txn(1'b0, 32'h3000_0040, 32'h0, 4'hF, 7, 32'h7777_0001, 0, 1'b0);
    chk("edge_bus_cycles", last_bus, 8);
    chk("edge_err", last_err, 0);
    chk("edge_rdata", last_rdata, 32'h7777_0001);

    // Reset during the second BUS cycle.
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 32'h3000_0050;
    cmd_wdata = 32'hBEEF_0000;
    cmd_sel   = 4'h5;
    step();
    exp_cmd_ready  = 1'b0;
    exp_cyc        = 1'b1;
    exp_rsp_valid  = 1'b0;
    exp_fields     = 1'b1;
    exp_we         = 1'b1;
    exp_addr       = 32'h3000_0050;
    exp_data       = 32'hBEEF_0000;
    exp_sel        = 4'h5;
    exp_rsp_fields = 1'b0;
    cmd_valid = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    expect_reset_values(1'b0);
    chk("midrst_cyc", o_wb_cyc, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    reset_n = 1'b1;
    step();
    expect_reset_values(1'b1);
    run_txn(1'b0, 32'h3000_0060, 32'h0, 4'hF, 2, 32'h0BAD_CAFE, 0, 1'b0);
    chk("post_rst_rdata", last_rdata, 32'h0BAD_CAFE);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 11)), $urandom, int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)));
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
